// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity encodings and the helpers
// that turn the register-level settings into per-frame values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DIV_W = 12;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
        case (sel)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b1;
        endcase
    endfunction

    // Divisor 0 means "use the build default"; 1 is too short for a bit period.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] baud_divisor,
                                                 input logic [DIV_W-1:0] default_div);
        if (baud_divisor == '0)
            return default_div;
        else if (baud_divisor == DIV_W'(1))
            return DIV_W'(2);
        else
            return baud_divisor;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: bit_end pulses on the last clock of every div-clock bit
// while run is high; restart realigns the count to a new frame.
module baud_tick_gen #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         restart,
    input  logic [W-1:0] div,
    output logic         bit_end
);
    logic [W-1:0] count;

    assign bit_end = run && (count == div - W'(1));

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
        if (!reset)
            count <= '0;
        else if (restart || !run || bit_end)
            count <= '0;
        else
            count <= count + W'(1);
    end

endmodule

// File: rtl/tx_shift_reg.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Define TX_BUFFER_EN to add a one-entry holding register for gapless frames.
module tx_shift_reg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DIV_W-1:0] baud_divisor,
    input  logic [1:0]       parity_sel,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_FREQ / BAUD_RATE);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]       state;
    logic [2:0]       bit_idx;
    logic [7:0]       frame_data;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       par_q;
    logic             accept;
    logic             start_now;
    logic             frame_end;
    logic             bit_end;
    logic [7:0]       start_data;

    assign accept    = tx_valid && tx_ready;
    assign frame_end = (state == ST_STOP) && bit_end;
    assign tx_busy   = (state != ST_IDLE);

`ifdef TX_BUFFER_EN
    logic [7:0] buf_data;
    logic       buf_full;
    logic       buf_wr;
    logic       buf_load;

    assign tx_ready = !buf_full;
    // At STOP end the buffered byte wins; an empty buffer lets the bus byte start directly.
    assign start_now  = ((state == ST_IDLE) || frame_end) && (buf_full || accept);
    assign start_data = buf_full ? buf_data : tx_data;
    assign buf_load   = start_now && buf_full;
    assign buf_wr     = accept && !(start_now && !buf_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            buf_full <= 1'b0;
        else if (buf_wr)
            buf_full <= 1'b1;
        else if (buf_load)
            buf_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (buf_wr)
            buf_data <= tx_data;
    end
`else
    assign tx_ready   = (state == ST_IDLE);
    assign start_now  = (state == ST_IDLE) && accept;
    assign start_data = tx_data;
`endif

    baud_tick_gen #(
        .W(DIV_W)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .run     (tx_busy),
        .restart (start_now),
        .div     (div_q),
        .bit_end (bit_end)
    );

    // NOTE: frame_data is only read while a frame runs, so it needs no reset.
    always_ff @(posedge clk) begin
        if (start_now)
            frame_data <= start_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            div_q   <= DEFAULT_DIV;
            par_q   <= PAR_NONE;
            tx_done <= 1'b0;
        end else begin
            tx_done <= frame_end;
            if (start_now) begin
                state   <= ST_START;
                bit_idx <= '0;
                div_q   <= eff_div(baud_divisor, DEFAULT_DIV);
                par_q   <= parity_sel;
            end else if (bit_end) begin
                case (state)
                    ST_START:  state <= ST_DATA;
                    ST_DATA: begin
                        if (bit_idx == 3'd7)
                            state <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                    ST_PARITY: state <= ST_STOP;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    // Decoded from state so an asynchronous reset returns the line high at once.
    always_comb begin
        // NOTE: default first so every path assigns tx_serial and no latch is inferred.
        tx_serial = 1'b1;
        case (state)
            ST_START:  tx_serial = 1'b0;
            ST_DATA:   tx_serial = frame_data[bit_idx];
            ST_PARITY: tx_serial = parity_bit(frame_data, par_q);
            default:   tx_serial = 1'b1;
        endcase
    end

endmodule
